// File: rtl/int_pkg.sv
// Shared types and helpers for the interrupt sequencer: FSM states, priority
// codes, context record, and code-to-mask / code-to-vector mapping.
package int_pkg;

    typedef enum logic [1:0] {IDLE, SAVE, ACK, RET} state_t;

    localparam logic [1:0] CODE_NONE = 2'b00;
    localparam logic [1:0] CODE_IR0  = 2'b01;
    localparam logic [1:0] CODE_IR1  = 2'b10;
    localparam logic [1:0] CODE_IR2  = 2'b11;

    // Context PC field is sized for the widest supported PC; narrower PCs zero-extend.
    localparam int CTX_PCW = 32;

    typedef struct packed {
        logic [CTX_PCW-1:0] pc;
        logic [3:0]         inm;
        logic               ie;
    } ctx_t;

    function automatic logic [3:0] code_to_mask(input logic [1:0] code);
        case (code)
            CODE_IR0: return 4'b0001;
            CODE_IR1: return 4'b0011;
            CODE_IR2: return 4'b0111;
            default:  return 4'b0000;
        endcase
    endfunction

    function automatic logic [3:0] code_to_ig(input logic [1:0] code);
        return {1'b0, code == CODE_IR2, code == CODE_IR1, code == CODE_IR0};
    endfunction

    function automatic logic [31:0] code_to_vec(input logic [1:0]  code,
                                                input logic [31:0] base,
                                                input logic [31:0] stride);
        return base + (32'(code) - 32'd1) * stride;
    endfunction

endpackage

// File: rtl/int_ctx_stack.sv
// Parameterised LIFO of saved interrupt contexts with occupancy count.
module int_ctx_stack #(
    parameter  int W     = 37,
    parameter  int DEPTH = 3,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          in_CLK,
    input  logic          in_RST,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] depth
);

    logic [DEPTH-1:0][W-1:0] mem;
    logic [CW-1:0]           cnt;

    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    assign depth = cnt;

    always_ff @(posedge in_CLK or posedge in_RST) begin
        if (in_RST) begin
            mem <= '0;
            cnt <= '0;
        end else if (push && !full) begin
            for (int i = 0; i < DEPTH; i++)
                if (CW'(i) == cnt) mem[i] <= wdata;
            cnt <= cnt + CW'(1);
        end else if (pop && !empty) begin
            cnt <= cnt - CW'(1);
        end
    end

    // Top-of-stack read; zero when empty.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < DEPTH; i++)
            if (CW'(i + 1) == cnt) rdata = mem[i];
    end

endmodule

// File: rtl/int_sequencer.sv
// Interrupt entry/return sequencer: saves context, loads vector PC, pulses IG,
// restores on ERET. Define INT_SEQ_NEST_EN to allow nesting up to DEPTH.
module int_sequencer
    import int_pkg::*;
#(
    parameter int          PCW        = 32,
    parameter int          DEPTH      = 3,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
    parameter int          VEC_STRIDE = 4
) (
    input  logic           in_CLK,
    input  logic           in_RST,
    input  logic           in_break,
    input  logic [1:0]     in_code,
    input  logic           in_boundary,
    input  logic [PCW-1:0] in_PC,
    input  logic           in_ERET,
    input  logic           in_IE_wr,
    input  logic           in_IE_data,
    output logic           out_stall,
    output logic           out_PC_load,
    output logic [PCW-1:0] out_PC,
    output logic [3:0]     out_IG,
    output logic [3:0]     out_INM,
    output logic           out_IE,
    output logic [1:0]     out_depth,
    output logic           out_err
);

`ifdef INT_SEQ_NEST_EN
    localparam int   EFF_DEPTH = DEPTH;
    localparam logic NEST      = 1'b1;
`else
    // Without nesting a single-entry stack is enough.
    localparam int   EFF_DEPTH = (DEPTH >= 1) ? 1 : DEPTH;
    localparam logic NEST      = 1'b0;
`endif
    localparam int CW = $clog2(EFF_DEPTH + 1);

    state_t          state, state_nx;
    logic [1:0]      code_q;
    logic [PCW-1:0]  pc_q;
    logic            take_brk, eret_empty;
    logic            full, empty;
    logic [CW-1:0]   cnt;
    ctx_t            push_ctx, top_ctx;
    logic [31:0]     vec_full;

    assign push_ctx = '{pc: CTX_PCW'(pc_q), inm: out_INM, ie: out_IE};
    assign vec_full = code_to_vec(code_q, VEC_BASE, 32'(VEC_STRIDE));
    assign out_depth = 2'(cnt);

    int_ctx_stack #(.W($bits(ctx_t)), .DEPTH(EFF_DEPTH)) u_stack (
        .in_CLK (in_CLK),
        .in_RST (in_RST),
        .push   (state == SAVE),
        .pop    (state == RET),
        .wdata  (push_ctx),
        .rdata  (top_ctx),
        .full   (full),
        .empty  (empty),
        .depth  (cnt)
    );

    always_ff @(posedge in_CLK or posedge in_RST) begin
        if (in_RST) begin
            state   <= IDLE;
            code_q  <= CODE_NONE;
            pc_q    <= '0;
            out_INM <= '0;
            out_IE  <= 1'b0;
            out_err <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    // IE write lands before a coinciding SAVE pushes the context.
                    if (in_IE_wr) out_IE <= in_IE_data;
                    if (take_brk) begin
                        code_q <= in_code;
                        pc_q   <= in_PC;
                    end
                    if (eret_empty) out_err <= 1'b1;
                end
                SAVE: begin
                    out_INM <= out_INM | code_to_mask(code_q);
                    out_IE  <= 1'b0;
                end
                ACK: out_IE <= NEST;
                RET: begin
                    out_INM <= top_ctx.inm;
                    out_IE  <= top_ctx.ie;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx    = state;
        take_brk    = 1'b0;
        eret_empty  = 1'b0;
        out_stall   = (state != IDLE);
        out_PC_load = 1'b0;
        out_PC      = '0;
        out_IG      = '0;
        case (state)
            IDLE: begin
                // ERET has priority over a break on the same boundary.
                if (in_boundary && in_ERET) begin
                    if (empty) eret_empty = 1'b1;
                    else       state_nx   = RET;
                end else if (in_boundary && in_break && in_code != CODE_NONE && !full) begin
                    take_brk = 1'b1;
                    state_nx = SAVE;
                end
            end
            SAVE: state_nx = ACK;
            ACK: begin
                out_PC_load = 1'b1;
                out_PC      = vec_full[PCW-1:0];
                out_IG      = code_to_ig(code_q);
                state_nx    = IDLE;
            end
            RET: begin
                out_PC_load = 1'b1;
                out_PC      = top_ctx.pc[PCW-1:0];
                state_nx    = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_int_sequencer.sv
// Scoreboard bench for int_sequencer: expected PC loads queued at stimulus time,
// compared when the DUT strobes out_PC_load; state checked after each sequence.
module tb_int_sequencer;

`ifdef INT_SEQ_NEST_EN
    localparam int   EFF  = 3;
    localparam logic NEST = 1'b1;
`else
    localparam int   EFF  = 1;
    localparam logic NEST = 1'b0;
`endif

    logic        in_CLK = 1'b0;
    logic        in_RST;
    logic        in_break, in_boundary, in_ERET, in_IE_wr, in_IE_data;
    logic [1:0]  in_code;
    logic [31:0] in_PC;
    logic        out_stall, out_PC_load, out_IE, out_err;
    logic [31:0] out_PC;
    logic [3:0]  out_IG, out_INM;
    logic [1:0]  out_depth;

    int_sequencer dut (
        .in_CLK(in_CLK), .in_RST(in_RST), .in_break(in_break), .in_code(in_code),
        .in_boundary(in_boundary), .in_PC(in_PC), .in_ERET(in_ERET),
        .in_IE_wr(in_IE_wr), .in_IE_data(in_IE_data), .out_stall(out_stall),
        .out_PC_load(out_PC_load), .out_PC(out_PC), .out_IG(out_IG),
        .out_INM(out_INM), .out_IE(out_IE), .out_depth(out_depth), .out_err(out_err)
    );

    always #5 in_CLK = ~in_CLK;

    typedef struct { logic [31:0] pc; logic [3:0] ig; } ld_t;
    typedef struct { logic [31:0] pc; logic [3:0] inm; logic ie; } mctx_t;

    ld_t   sb[$];
    mctx_t stk[$];
    ld_t   mon_e;
    int    checks = 0, failures = 0;
    int    m_depth;
    logic [3:0] m_inm;
    logic  m_ie, m_err;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_vec(input logic [1:0] c);
        case (c)
            2'd1:    return 32'h100;
            2'd2:    return 32'h104;
            default: return 32'h108;
        endcase
    endfunction

    function automatic logic [3:0] exp_mask(input logic [1:0] c);
        case (c)
            2'd1:    return 4'b0001;
            2'd2:    return 4'b0011;
            default: return 4'b0111;
        endcase
    endfunction

    function automatic logic [3:0] exp_ig(input logic [1:0] c);
        case (c)
            2'd1:    return 4'b0001;
            2'd2:    return 4'b0010;
            default: return 4'b0100;
        endcase
    endfunction

    always @(negedge in_CLK) begin
        if (!in_RST && out_PC_load) begin
            if (sb.size() == 0) chk("load_without_expect", 1, 0);
            else begin
                mon_e = sb.pop_front();
                chk("load_pc", out_PC, mon_e.pc);
                chk("load_ig", out_IG, mon_e.ig);
            end
        end
    end

    task automatic clr_in();
        in_break = 0; in_boundary = 0; in_ERET = 0; in_IE_wr = 0; in_IE_data = 0;
        in_code = 0; in_PC = 0;
    endtask

    task automatic post(input string tag);
        chk({tag, "_stall"}, out_stall, 0);
        chk({tag, "_depth"}, out_depth, 64'(m_depth));
        chk({tag, "_inm"},   out_INM, m_inm);
        chk({tag, "_ie"},    out_IE, m_ie);
        chk({tag, "_err"},   out_err, m_err);
    endtask

    // One instruction boundary (or plain cycle when b=0) issued from IDLE.
    task automatic bnd(input string tag, input logic b, input logic [31:0] pc,
                       input logic brk, input logic [1:0] code, input logic eret,
                       input logic iew, input logic ied);
        int    act;
        mctx_t c;
        @(negedge in_CLK);
        in_boundary = b; in_PC = pc; in_break = brk; in_code = code;
        in_ERET = eret; in_IE_wr = iew; in_IE_data = ied;
        if (iew) m_ie = ied;
        act = 0;
        if (b && eret) begin
            if (m_depth > 0) begin
                act = 2;
                c = stk.pop_back();
                sb.push_back('{pc: c.pc, ig: 4'b0000});
                m_inm = c.inm; m_ie = c.ie; m_depth--;
            end else m_err = 1'b1;
        end else if (b && brk && code != 2'b00 && m_depth < EFF) begin
            act = 1;
            stk.push_back('{pc: pc, inm: m_inm, ie: m_ie});
            sb.push_back('{pc: exp_vec(code), ig: exp_ig(code)});
            m_inm = m_inm | exp_mask(code);
            m_ie  = NEST;
            m_depth++;
        end
        @(negedge in_CLK);
        clr_in();
        if (act == 1) begin
            chk({tag, "_save_stall"}, out_stall, 1);
            chk({tag, "_save_noload"}, out_PC_load, 0);
            @(negedge in_CLK);
            chk({tag, "_ack_load"}, out_PC_load, 1);
            @(negedge in_CLK);
        end else if (act == 2) begin
            chk({tag, "_ret_load"}, out_PC_load, 1);
            @(negedge in_CLK);
        end else begin
            chk({tag, "_idle_stall"}, out_stall, 0);
            chk({tag, "_idle_noload"}, out_PC_load, 0);
        end
        post(tag);
    endtask

    initial begin
        clr_in();
        in_RST = 1'b1;
        m_depth = 0; m_inm = 0; m_ie = 0; m_err = 0;
        #1;
        chk("rst_stall", out_stall, 0);
        chk("rst_load",  out_PC_load, 0);
        chk("rst_pc",    out_PC, 0);
        chk("rst_ig",    out_IG, 0);
        chk("rst_inm",   out_INM, 0);
        chk("rst_ie",    out_IE, 0);
        chk("rst_depth", out_depth, 0);
        chk("rst_err",   out_err, 0);
        repeat (2) @(negedge in_CLK);
        in_RST = 1'b0;

        bnd("ie_on",    0, 32'h0,   0, 2'd0, 0, 1, 1);
        bnd("entry_ir1",1, 32'h40,  1, 2'd2, 0, 0, 0);
        bnd("nest_ir2", 1, 32'h108, 1, 2'd3, 0, 0, 0);
        bnd("nest_3",   1, 32'h10C, 1, 2'd3, 0, 0, 0);
        bnd("full_ign", 1, 32'h110, 1, 2'd1, 0, 0, 0);
        repeat (EFF) bnd("unwind", 1, 32'h200, 0, 2'd0, 1, 0, 0);
        bnd("eret_empty", 1, 32'h204, 0, 2'd0, 1, 0, 0);
        bnd("iew_brk",  1, 32'h300, 1, 2'd1, 0, 1, 1);
        bnd("eret_win", 1, 32'h304, 1, 2'd3, 1, 0, 0);
        bnd("brk_after",1, 32'h308, 1, 2'd3, 0, 0, 0);
        bnd("ret_again",1, 32'h30C, 0, 2'd0, 1, 0, 0);
        bnd("code00",   1, 32'h310, 1, 2'd0, 0, 0, 0);
        bnd("no_bnd",   0, 32'h314, 1, 2'd2, 0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            bnd("rnd", ($urandom % 4) != 0, $urandom & 32'hFFFF_FFFC, $urandom % 2,
                2'($urandom % 4), ($urandom % 3) == 0, ($urandom % 5) == 0, $urandom % 2);
        end
        repeat (EFF) if (m_depth > 0) bnd("drain", 1, 32'h400, 0, 2'd0, 1, 0, 0);
        chk("sb_drained", 64'(sb.size()), 0);

        // Reset while in SAVE: everything drops at once, no IG pulse follows.
        @(negedge in_CLK);
        in_boundary = 1; in_break = 1; in_code = 2'd1; in_PC = 32'h500;
        @(posedge in_CLK);
        #2;
        chk("pre_rst_save_stall", out_stall, 1);
        in_RST = 1'b1;
        #1;
        chk("arst_stall", out_stall, 0);
        chk("arst_load",  out_PC_load, 0);
        chk("arst_ig",    out_IG, 0);
        chk("arst_inm",   out_INM, 0);
        chk("arst_ie",    out_IE, 0);
        chk("arst_depth", out_depth, 0);
        chk("arst_err",   out_err, 0);
        clr_in();
        sb.delete(); stk.delete();
        m_depth = 0; m_inm = 0; m_ie = 0; m_err = 0;
        repeat (2) @(negedge in_CLK);
        in_RST = 1'b0;
        repeat (3) begin
            @(negedge in_CLK);
            chk("post_rst_ig",   out_IG, 0);
            chk("post_rst_load", out_PC_load, 0);
        end
        bnd("recover", 1, 32'h600, 1, 2'd2, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
